// File: rtl/protection_trap_unit.sv
// Trap sequencer for memory-protection violations: flush, capture fault state, vector to kernel, return to user.
// Optional macro TRAP_FAULT_COUNT_EN adds a saturating fault_count output.
module protection_trap_unit #(
  parameter logic [15:0] VECTOR_ADDR  = 16'h0010,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Illegal_PC,
  input  logic        Illegal_Memory,
  input  logic [15:0] Current_PC,
  input  logic [15:0] p0,
  input  logic        trap_ret,
  output logic [1:0]  Mode,
  output logic        flush,
  output logic        redirect,
  output logic [15:0] redirect_pc,
  output logic [15:0] epc,
  output logic [1:0]  fault_cause,
  output logic [15:0] fault_addr,
  output logic        halted
`ifdef TRAP_FAULT_COUNT_EN
  ,
  output logic [7:0]  fault_count
`endif
);

  localparam int unsigned AW = 16;
  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYCLES - 1);
  localparam logic [1:0] MODE_KERNEL = 2'b00;
  localparam logic [1:0] MODE_USER   = 2'b01;
  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_PC    = 2'b01;
  localparam logic [1:0] CAUSE_MEM   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_VECTOR, S_HANDLER, S_RETURN, S_HALT
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] epc_nxt, addr_nxt, rpc_nxt;
  logic [1:0]    cause_nxt, mode_nxt;
  logic          flush_nxt, redirect_nxt, halted_nxt;
  logic          violation;

  assign violation = Illegal_PC | Illegal_Memory;

  // Next-state and next-output logic; outputs are registered from the upcoming state
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    epc_nxt   = epc;
    cause_nxt = fault_cause;
    addr_nxt  = fault_addr;
    rpc_nxt   = redirect_pc;
    unique case (state)
      S_IDLE: begin
        if (violation) begin
          state_nxt = S_FLUSH;
          cnt_nxt   = '0;
          epc_nxt   = Current_PC;
          if (Illegal_PC) begin
            cause_nxt = CAUSE_PC;
            addr_nxt  = Current_PC;
          end else begin
            cause_nxt = CAUSE_MEM;
            addr_nxt  = p0;
          end
        end
      end
      S_FLUSH: begin
        if (cnt == FLUSH_LAST) begin
          state_nxt = S_VECTOR;
          rpc_nxt   = VECTOR_ADDR;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_VECTOR: state_nxt = S_HANDLER;
      S_HANDLER: begin
        // A violation inside the handler is a double fault and beats trap_ret
        if (violation) begin
          state_nxt = S_HALT;
        end else if (trap_ret) begin
          state_nxt = S_RETURN;
          rpc_nxt   = epc + AW'(1);
        end
      end
      S_RETURN: begin
        state_nxt = S_IDLE;
        cause_nxt = CAUSE_NONE;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase

    redirect_nxt = (state_nxt == S_VECTOR) || (state_nxt == S_RETURN);
    flush_nxt    = (state_nxt != S_IDLE) && (state_nxt != S_HANDLER);
    mode_nxt     = ((state_nxt == S_IDLE) || (state_nxt == S_FLUSH)) ? MODE_USER : MODE_KERNEL;
    halted_nxt   = (state_nxt == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      Mode        <= MODE_USER;
      flush       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      epc         <= '0;
      fault_cause <= CAUSE_NONE;
      fault_addr  <= '0;
      halted      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      Mode        <= mode_nxt;
      flush       <= flush_nxt;
      redirect    <= redirect_nxt;
      redirect_pc <= rpc_nxt;
      epc         <= epc_nxt;
      fault_cause <= cause_nxt;
      fault_addr  <= addr_nxt;
      halted      <= halted_nxt;
    end
  end

`ifdef TRAP_FAULT_COUNT_EN
  // Counts first-level traps only; double faults never leave HANDLER through IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_count <= '0;
    end else if ((state == S_IDLE) && violation && (fault_count != 8'hFF)) begin
      fault_count <= fault_count + 8'(1);
    end
  end
`endif

endmodule
